// File: rtl/decoder_pkg.sv
// Shared types and the 2-to-4 decode helper for the decoder block.
package decoder_pkg;

  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;

  localparam onehot_t ONEHOT_NONE = 4'b0000;

  // Bundle of every decoder output, used to move results between stages.
  typedef struct packed {
    logic    out;
    onehot_t onehot;
    logic    sum;
    logic    carry;
    logic    valid;
  } dec_res_t;

  localparam dec_res_t DEC_RES_IDLE = '{out: 1'b0, onehot: ONEHOT_NONE,
                                        sum: 1'b0, carry: 1'b0, valid: 1'b0};

  // Bit index of the single set bit equals the code value.
  function automatic onehot_t dec2(code_t c);
    onehot_t base;
    base = 4'b0001;
    return onehot_t'(base << c);
  endfunction

endpackage

// File: rtl/decoder_comb.sv
// Pure combinational decode of en/{in1,in2}. With en low every output is zero
// so downstream enables never see a stale or partial decode.
module decoder_comb
  import decoder_pkg::*;
(
  input  logic     en,
  input  logic     in1,
  input  logic     in2,
  output dec_res_t res
);

  code_t code;
  assign code = {in1, in2};

  // Decode the code when enabled, otherwise drive the idle (all-zero) result.
  always_comb begin
    res = DEC_RES_IDLE;
    if (en) begin
      res.onehot = dec2(code);
      res.out    = in1 & in2;
      res.carry  = in1 & in2;
      res.sum    = in1 ^ in2;
      res.valid  = 1'b1;
    end
  end

endmodule

// File: rtl/decoder.sv
// 2-input decoder/match unit: one-hot decode, all-ones match flag and
// half-adder sum/carry. OUT_REG=1 registers all outputs (1-cycle latency);
// OUT_REG=0 is a purely combinational path and ignores clk/rst.
//
// valid: there is no back-pressure. valid=1 means the other outputs hold the
// decode of an enabled sample; valid=0 means every other output is zero.
module decoder
  import decoder_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in1,
  input  logic       in2,
  output logic       out,
  output logic [3:0] onehot,
  output logic       sum,
  output logic       carry,
  output logic       valid
);

  dec_res_t comb_res;
  dec_res_t res;

  decoder_comb u_comb (
    .en  (en),
    .in1 (in1),
    .in2 (in2),
    .res (comb_res)
  );

  generate
    if (OUT_REG) begin : g_reg
      // Output register; reset wins over en, and en=0 clears rather than holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          res <= DEC_RES_IDLE;
        end else begin
          res <= comb_res;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign res = comb_res;
    end
  endgenerate

  assign out    = res.out;
  assign onehot = res.onehot;
  assign sum    = res.sum;
  assign carry  = res.carry;
  assign valid  = res.valid;

`ifdef ASSERT_ON
  a_onehot0 : assert property (@(posedge clk) $onehot0(onehot));
  a_out_msb : assert property (@(posedge clk) out == onehot[3]);
  a_carry   : assert property (@(posedge clk) carry == out);
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: a registered instance driven through the
// clock-by-clock sequences, plus a combinational (OUT_REG=0) instance.
module tb_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in1;
  logic       in2;
  logic       out;
  logic [3:0] onehot;
  logic       sum;
  logic       carry;
  logic       valid;

  logic       c_en;
  logic       c_in1;
  logic       c_in2;
  logic       c_out;
  logic [3:0] c_onehot;
  logic       c_sum;
  logic       c_carry;
  logic       c_valid;

  int checks   = 0;
  int failures = 0;

  // Expected result packed as {out, onehot[3:0], sum, carry, valid}.
  logic [7:0] exp_q[$];

  decoder #(.OUT_REG(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in1    (in1),
    .in2    (in2),
    .out    (out),
    .onehot (onehot),
    .sum    (sum),
    .carry  (carry),
    .valid  (valid)
  );

  decoder #(.OUT_REG(1'b0)) dut_comb (
    .clk    (clk),
    .rst    (rst),
    .en     (c_en),
    .in1    (c_in1),
    .in2    (c_in2),
    .out    (c_out),
    .onehot (c_onehot),
    .sum    (c_sum),
    .carry  (c_carry),
    .valid  (c_valid)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, expv);
      $error("check %s did not match", tag);
    end
  endtask

  // Driver: apply one sample at the falling edge, queue its expected result,
  // then compare just after the rising edge that registers it.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic a, input logic b,
                      input logic x_out, input logic [3:0] x_oh,
                      input logic x_sum, input logic x_valid);
    logic [7:0] expv;
    @(negedge clk);
    rst = r;
    en  = e;
    in1 = a;
    in2 = b;
    exp_q.push_back({x_out, x_oh, x_sum, x_out, x_valid});
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    chk(tag, {out, onehot, sum, carry, valid}, expv);
  endtask

  // Combinational instance: outputs must follow inputs with no clock.
  task automatic comb_step(input string tag, input logic e, input logic a, input logic b,
                           input logic x_out, input logic [3:0] x_oh,
                           input logic x_sum, input logic x_valid);
    c_en  = e;
    c_in1 = a;
    c_in2 = b;
    #1;
    chk(tag, {c_out, c_onehot, c_sum, c_carry, c_valid},
        {x_out, x_oh, x_sum, x_out, x_valid});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in1 = 1'b1; in2 = 1'b1;
    c_en = 1'b0; c_in1 = 1'b0; c_in2 = 1'b0;

    // Reset held for two clocks with an active all-ones code applied.
    step("reset_1", 1, 1, 1, 1, 0, 4'b0000, 0, 0);
    step("reset_2", 1, 1, 1, 1, 0, 4'b0000, 0, 0);

    // Sweep all codes with en=1.
    step("sweep_00", 0, 1, 0, 0, 0, 4'b0001, 0, 1);
    step("sweep_01", 0, 1, 0, 1, 0, 4'b0010, 1, 1);
    step("sweep_10", 0, 1, 1, 0, 0, 4'b0100, 1, 1);
    step("sweep_11", 0, 1, 1, 1, 1, 4'b1000, 0, 1);

    // Enable gating clears outputs instead of holding them.
    step("gate_en0_11", 0, 0, 1, 1, 0, 4'b0000, 0, 0);
    step("gate_en1_11", 0, 1, 1, 1, 1, 4'b1000, 0, 1);
    step("gate_en0_01", 0, 0, 0, 1, 0, 4'b0000, 0, 0);
    step("gate_en1_10", 0, 1, 1, 0, 0, 4'b0100, 1, 1);

    // Mid-stream reset pulse, then immediate decode with no bubble.
    step("mid_pre", 0, 1, 1, 1, 1, 4'b1000, 0, 1);
    step("mid_rst", 1, 1, 1, 1, 0, 4'b0000, 0, 0);
    step("mid_post", 0, 1, 1, 1, 1, 4'b1000, 0, 1);

    // Back-to-back toggle 11/00.
    step("tog_00a", 0, 1, 0, 0, 0, 4'b0001, 0, 1);
    step("tog_11a", 0, 1, 1, 1, 1, 4'b1000, 0, 1);
    step("tog_00b", 0, 1, 0, 0, 0, 4'b0001, 0, 1);
    step("tog_11b", 0, 1, 1, 1, 1, 4'b1000, 0, 1);

    // Reset takes priority over en=0 as well.
    step("rst_en0", 1, 0, 0, 1, 0, 4'b0000, 0, 0);

    // Combinational build.
    comb_step("comb_00", 1, 0, 0, 0, 4'b0001, 0, 1);
    comb_step("comb_01", 1, 0, 1, 0, 4'b0010, 1, 1);
    comb_step("comb_10", 1, 1, 0, 0, 4'b0100, 1, 1);
    comb_step("comb_11", 1, 1, 1, 1, 4'b1000, 0, 1);
    comb_step("comb_en0", 0, 1, 1, 0, 4'b0000, 0, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
